seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Downstream display stage for the BCD load/count digit blocks. It takes the 7-segment patterns those blocks drive on their Q_out (7-bit) outputs, N_DIGITS digits side by side.
- It time-multiplexes them onto one shared segment bus plus per-digit anode enables for a common-anode display.
- Incoming patterns are double-buffered so the display never shows a half-updated frame.
- Anode switching inserts a blanking gap to suppress ghosting.

Parameters:
- N_DIGITS, 4, number of digits scanned; range 2..8.
- DIV, 50000, clk cycles per digit slot; must be >= BLANK_CYC+2.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off; 0 means no gap.
- AN_ACTIVE_LOW, 1, 1 = an_out active-low, 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst_asyn  in  1  asynchronous active-low reset.
- upd  in  1  one-cycle strobe; captures seg_in into the pending buffer.
- seg_in  in  7*N_DIGITS  digit patterns, digit k at bits [7k+6:7k]; within a digit bit6=a … bit0=g, active-high (same as Q_out).
- seg_out  out  7  segment drive for the current digit, active-high, abcdefg.
- an_out  out  N_DIGITS  anode enables, one-hot when lit, polarity per AN_ACTIVE_LOW.
- digit_idx  out  clog2(N_DIGITS)  index of the slot currently owned.
- frame_start  out  1  one-cycle pulse when the slot index wraps to 0.

Behaviour:
- Reset (rst_asyn=0, asynchronous), all registers cleared:
  - prescaler=0, digit_idx=0, blank_cnt=BLANK_CYC, pending and active buffers all 0, pend_valid=0.
  - seg_out=0, an_out all inactive, frame_start=0.
  - Release is synchronous to the next clk edge; the first slot starts with its blank window.
- Prescaler counts 0..DIV-1 and wraps. tick = (prescaler==DIV-1).
- On tick:
  - digit_idx <= (digit_idx==N_DIGITS-1) ? 0 : digit_idx+1.
  - blank_cnt <= BLANK_CYC.
  - If the wrap is to 0, frame_start pulses on the following cycle.
- Blank window: while blank_cnt != 0, blank_cnt decrements each cycle, an_out is all inactive and seg_out=0.
- Lit phase: when blank_cnt==0, an_out asserts only bit digit_idx and seg_out = active[digit_idx].
- seg_out and an_out are registered: they reflect digit_idx/blank_cnt state with exactly 1 cycle latency.
- Anode and segments change on the same edge, so no cycle ever has a lit anode with another digit's segments.
- Buffering:
  - upd=1 copies seg_in into pending and sets pend_valid.
  - On a tick that wraps digit_idx to 0 with pend_valid=1, pending is copied to active and pend_valid is cleared.
  - upd on a non-wrap cycle: last write wins; pending is overwritten.
  - upd on the same cycle as a wrap tick: seg_in goes directly into active, pend_valid ends 0, and the new frame displays from digit 0.
- seg_in is ignored when upd=0.
- Mid-operation reset: all state is lost, including pending data. The display blanks immediately (asynchronously) and restarts from digit 0.

Optional Feature:
- Macro: SEVEN_SEG_SCAN_BLANK_LEADING_EN.
- When defined: during the lit phase, digit k is suppressed if it and every higher digit (k..N_DIGITS-1) in active equal the zero pattern 7'h7E. Suppressed means seg_out=0 and its anode stays inactive. Digit 0 is never suppressed.
- When undefined: all digits display unconditionally. No extra logic is synthesised.

Test Plan:
- Common settings: N_DIGITS=4, DIV=4, BLANK_CYC=1, AN_ACTIVE_LOW=1.
- Reset hold, then release -> an_out=4'b1111 and seg_out=0 while reset is low. After release, digit_idx sequence is 0,1,2,3,0 with 4 cycles per slot, and frame_start pulses once per 16 cycles.
- upd with seg_in={7'h30,7'h6D,7'h79,7'h7E} mid-frame -> display is unchanged until the wrap. From the next frame, slot 0 shows 7'h7E with an_out=4'b1110 and slot 3 shows 7'h30 with an_out=4'b0111. In each slot the first lit cycle comes after 1 blank cycle plus 1 latency cycle.
- Two upd pulses in one frame (patterns A, then B) -> only B is ever displayed.
- upd coincident with the wrap tick -> the new data is visible in slot 0 of the immediately following frame, and pend_valid=0 afterwards.
- rst_asyn pulled low while slot 2 is lit -> an_out goes to 4'b1111 with no clock edge. After release, the scan restarts at digit 0 with the active buffer all 0.
- With SEVEN_SEG_SCAN_BLANK_LEADING_EN defined, active={7'h7E,7'h7E,7'h30,7'h7E} -> slots 3 and 2 stay dark, and slots 1 (7'h30) and 0 (7'h7E) light.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment scanner for a common-anode display.
// Digit patterns are double-buffered (pending -> active at frame wrap) and each
// digit slot opens with a blanking gap to suppress ghosting.
// Optional macro SEVEN_SEG_SCAN_BLANK_LEADING_EN: hide leading zero digits.
module seven_seg_scan #(
   parameter int unsigned N_DIGITS      = 4,
   parameter int unsigned DIV           = 50000,
   parameter int unsigned BLANK_CYC     = 2,
   parameter int unsigned AN_ACTIVE_LOW = 1
) (
   input  logic                        clk,
   input  logic                        rst_asyn,
   input  logic                        upd,
   input  logic [7*N_DIGITS-1:0]       seg_in,
   output logic [6:0]                  seg_out,
   output logic [N_DIGITS-1:0]         an_out,
   output logic [$clog2(N_DIGITS)-1:0] digit_idx,
   output logic                        frame_start
);

   localparam int unsigned IdxW   = $clog2(N_DIGITS);
   localparam int unsigned PreW   = $clog2(DIV);
   localparam int unsigned BlankW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

   localparam logic [PreW-1:0]   PreMax    = PreW'(DIV - 1);
   localparam logic [IdxW-1:0]   IdxMax    = IdxW'(N_DIGITS - 1);
   localparam logic [BlankW-1:0] BlankInit = BlankW'(BLANK_CYC);

   logic [PreW-1:0]               presc_q;
   logic [IdxW-1:0]               idx_q;
   logic [BlankW-1:0]             blank_q;
   logic                          fs_q;
   logic [N_DIGITS-1:0][6:0]      pend_q;
   logic [N_DIGITS-1:0][6:0]      act_q;
   logic                          pend_valid_q;
   logic [6:0]                    seg_q;
   logic [N_DIGITS-1:0]           an_q;

   logic                          tick;
   logic                          wrap;
   logic                          lit;
   logic [N_DIGITS-1:0]           suppress;
   logic [6:0]                    seg_d;
   logic [N_DIGITS-1:0]           an_d;

   assign tick = (presc_q == PreMax);
   assign wrap = tick && (idx_q == IdxMax);

`ifdef SEVEN_SEG_SCAN_BLANK_LEADING_EN
   // Digit k is hidden when it and all higher digits show the zero pattern.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      suppress = '0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_run    = zero_run && (act_q[k] == 7'h7E);
         suppress[k] = zero_run;
      end
   end
`else
   assign suppress = '0;
`endif

   assign lit = (blank_q == '0) && !suppress[idx_q];

   // Slot timing: prescaler, digit index, blank window and frame pulse.
   always_ff @(posedge clk or negedge rst_asyn) begin
      if (!rst_asyn) begin
         presc_q <= '0;
         idx_q   <= '0;
         blank_q <= BlankInit;
         fs_q    <= 1'b0;
      end else begin
         fs_q <= wrap;
         if (tick) begin
            presc_q <= '0;
            idx_q   <= wrap ? '0 : idx_q + 1'b1;
            blank_q <= BlankInit;
         end else begin
            presc_q <= presc_q + 1'b1;
            if (blank_q != '0) begin
               blank_q <= blank_q - 1'b1;
            end
         end
      end
   end

   // Double buffer: active only changes at a frame wrap, so frames never tear.
   always_ff @(posedge clk or negedge rst_asyn) begin
      if (!rst_asyn) begin
         pend_q       <= '0;
         act_q        <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         if (upd) begin
            pend_q <= seg_in;
         end
         if (wrap && upd) begin
            // Fresh data on the wrap edge bypasses pending entirely.
            act_q        <= seg_in;
            pend_valid_q <= 1'b0;
         end else if (wrap && pend_valid_q) begin
            act_q        <= pend_q;
            pend_valid_q <= 1'b0;
         end else if (upd) begin
            pend_valid_q <= 1'b1;
         end
      end
   end

   // Decode the current slot into segment and one-hot anode drive.
   always_comb begin
      seg_d = '0;
      an_d  = '0;
      if (lit) begin
         seg_d        = act_q[idx_q];
         an_d[idx_q]  = 1'b1;
      end
   end

   // Anode and segments register on the same edge to avoid cross-digit ghosts.
   always_ff @(posedge clk or negedge rst_asyn) begin
      if (!rst_asyn) begin
         seg_q <= '0;
         an_q  <= '0;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg_out     = seg_q;
   assign an_out      = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
   assign digit_idx   = idx_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with an expected-slot scoreboard.
// Honours SEVEN_SEG_SCAN_BLANK_LEADING_EN when building expected frames.
module tb_seven_seg_scan;

   logic        clk;
   logic        rst_asyn;
   logic        upd;
   logic [27:0] seg_in;
   logic [6:0]  seg_out;
   logic [3:0]  an_out;
   logic [1:0]  digit_idx;
   logic        frame_start;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [27:0] DataD = {7'h30, 7'h6D, 7'h79, 7'h7E};
   localparam logic [27:0] DataA = {7'h06, 7'h5B, 7'h4F, 7'h66};
   localparam logic [27:0] DataB = {7'h6D, 7'h7D, 7'h07, 7'h7F};
   localparam logic [27:0] DataC = {7'h77, 7'h1F, 7'h4E, 7'h3D};
   localparam logic [27:0] DataL = {7'h7E, 7'h7E, 7'h30, 7'h7E};

   seven_seg_scan #(
      .N_DIGITS      (4),
      .DIV           (4),
      .BLANK_CYC     (1),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst_asyn    (rst_asyn),
      .upd         (upd),
      .seg_in      (seg_in),
      .seg_out     (seg_out),
      .an_out      (an_out),
      .digit_idx   (digit_idx),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   // Expected lit-phase drive for each slot of one frame showing d.
   task automatic push_frame(input logic [27:0] d);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.seg = d[7*k +: 7];
         e.an  = ~(4'b0001 << k);
`ifdef SEVEN_SEG_SCAN_BLANK_LEADING_EN
         begin
            bit zr;
            zr = 1'b1;
            for (int j = k; j < 4; j++) zr = zr && (d[7*j +: 7] == 7'h7E);
            if (k > 0 && zr) begin
               e.seg = 7'h00;
               e.an  = 4'b1111;
            end
         end
`endif
         exp_q.push_back(e);
      end
   endtask

   // Checks one full frame (4 slots x (1 blank + 3 lit) samples); optional upd injections.
   task automatic run_frame(input bit wait_fs,
                            input int s1, input int p1, input logic [27:0] d1,
                            input int s2, input int p2, input logic [27:0] d2);
      exp_t e;
      e = '0;
      if (wait_fs) begin
         int n;
         n = 0;
         while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
      end
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            upd = 1'b0;
            if (p == 0) begin
               chk("blank_an", {28'd0, an_out}, 32'hF);
               chk("blank_seg", {25'd0, seg_out}, 32'd0);
               chk("slot_idx", {30'd0, digit_idx}, k);
               chk("fs_low", {31'd0, frame_start}, 32'd0);
            end else begin
               if (p == 1) begin
                  chk("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                  if (exp_q.size() > 0) e = exp_q.pop_front();
               end
               chk("lit_an", {28'd0, an_out}, {28'd0, e.an});
               chk("lit_seg", {25'd0, seg_out}, {25'd0, e.seg});
            end
            if (k == s1 && p == p1) begin
               upd = 1'b1;
               seg_in = d1;
            end
            if (k == s2 && p == p2) begin
               upd = 1'b1;
               seg_in = d2;
            end
         end
      end
      chk("frame_wrap", {31'd0, frame_start}, 32'd1);
   endtask

   initial begin
      rst_asyn = 1'b0;
      upd      = 1'b0;
      seg_in   = '0;

      // Reset hold.
      repeat (3) @(negedge clk);
      chk("rst_an", {28'd0, an_out}, 32'hF);
      chk("rst_seg", {25'd0, seg_out}, 32'd0);
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
      chk("rst_idx", {30'd0, digit_idx}, 32'd0);
      rst_asyn = 1'b1;

      // First frame after release: blank active buffer.
      push_frame(28'd0);
      run_frame(1'b0, -1, 0, 28'd0, -1, 0, 28'd0);

      // Mid-frame update is held until the wrap.
      push_frame(28'd0);
      run_frame(1'b1, 1, 0, DataD, -1, 0, 28'd0);
      push_frame(DataD);
      run_frame(1'b1, -1, 0, 28'd0, -1, 0, 28'd0);

      // Two updates in one frame: only the last is shown.
      push_frame(DataD);
      run_frame(1'b1, 1, 1, DataA, 2, 2, DataB);
      push_frame(DataB);
      run_frame(1'b1, -1, 0, 28'd0, -1, 0, 28'd0);

      // Update coincident with the wrap tick goes straight to active.
      push_frame(DataB);
      run_frame(1'b1, 3, 2, DataC, -1, 0, 28'd0);
      chk("pend_valid_after_wrap_upd", {31'd0, dut.pend_valid_q}, 32'd0);
      push_frame(DataC);
      run_frame(1'b1, -1, 0, 28'd0, -1, 0, 28'd0);

      // Reset while slot 2 is lit.
      repeat (10) @(negedge clk);
      chk("slot2_lit_an", {28'd0, an_out}, 32'hB);
      chk("slot2_lit_seg", {25'd0, seg_out}, {25'd0, DataC[20:14]});
      #2 rst_asyn = 1'b0;
      #1;
      chk("async_rst_an", {28'd0, an_out}, 32'hF);
      chk("async_rst_seg", {25'd0, seg_out}, 32'd0);
      chk("async_rst_idx", {30'd0, digit_idx}, 32'd0);
      @(negedge clk);
      rst_asyn = 1'b1;
      push_frame(28'd0);
      run_frame(1'b0, -1, 0, 28'd0, -1, 0, 28'd0);

      // Leading-zero pattern frame.
      push_frame(28'd0);
      run_frame(1'b1, 0, 1, DataL, -1, 0, 28'd0);
      push_frame(DataL);
      run_frame(1'b1, -1, 0, 28'd0, -1, 0, 28'd0);

      chk("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
